// File: rtl/muldiv_pipeline_sequencer.sv
// Sequencer for the shared iterative multiplier/divider in EX: issues start/abort
// pulses, counts fixed unit latency and merges the load-use stall into one stall set.
module muldiv_pipeline_sequencer #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_valid,
  input  logic ex_is_mul,
  input  logic ex_is_div,
  input  logic ex_divisor_zero,
  input  logic ex_flush,
  input  logic load_use_stall,
  output logic mul_start,
  output logic div_start,
  output logic unit_abort,
  output logic stall_front,
  output logic id_ex_bubble,
  output logic ex_mem_bubble,
  output logic result_valid,
  output logic result_sel,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sel_q, sel_nx;
  logic             md_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sel_q <= sel_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    sel_nx       = sel_q;
    mul_start    = 1'b0;
    div_start    = 1'b0;
    unit_abort   = 1'b0;
    result_valid = 1'b0;
    md_stall     = 1'b0;
    unique case (state)
      IDLE: begin
        // Issue is gated by rst so no start pulse escapes while reset is held.
        if (!rst && ex_valid && (ex_is_mul || ex_is_div) && !ex_flush) begin
          md_stall = 1'b1;
          if (ex_is_div) begin
            sel_nx = 1'b1;
            if (ex_divisor_zero) begin
              state_nx = DONE;
            end else begin
              div_start = 1'b1;
              cnt_nx    = DIV_LOAD;
              state_nx  = DIV_RUN;
            end
          end else begin
            mul_start = 1'b1;
            sel_nx    = 1'b0;
            cnt_nx    = MUL_LOAD;
            state_nx  = MUL_RUN;
          end
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (ex_flush) begin
          unit_abort = 1'b1;
          state_nx   = IDLE;
        end else begin
          md_stall = 1'b1;
          if (cnt == '0) state_nx = DONE;
          else           cnt_nx   = cnt - 1'b1;
        end
      end
      DONE: begin
        if (ex_flush) unit_abort   = 1'b1;
        else          result_valid = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stall_front   = md_stall | load_use_stall;
  assign id_ex_bubble  = load_use_stall & ~md_stall;
  assign ex_mem_bubble = md_stall;
  assign result_sel    = sel_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_muldiv_pipeline_sequencer.sv
// Bench for muldiv_pipeline_sequencer: directed and random stimulus checked
// against an op-position model (issue / run / done phases of each operation).
module tb_muldiv_pipeline_sequencer;

  localparam int MUL_N = 2;
  localparam int DIV_N = 32;

  logic clk = 1'b0;
  logic rst;
  logic ex_valid, ex_is_mul, ex_is_div, ex_divisor_zero, ex_flush, load_use_stall;
  logic mul_start, div_start, unit_abort, stall_front, id_ex_bubble;
  logic ex_mem_bubble, result_valid, result_sel, busy;

  int n_assert = 0;
  int n_fail   = 0;

  // model: an op in EX is at position 0 (issue), 1..len (run), len+1 (done)
  bit m_active;
  int m_pos;
  int m_len;
  bit m_sel;

  logic o_stall, o_ms, o_ds, o_rv, o_ab;

  always #5 clk = ~clk;

  muldiv_pipeline_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_mul(ex_is_mul), .ex_is_div(ex_is_div),
    .ex_divisor_zero(ex_divisor_zero), .ex_flush(ex_flush), .load_use_stall(load_use_stall),
    .mul_start(mul_start), .div_start(div_start), .unit_abort(unit_abort),
    .stall_front(stall_front), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .result_valid(result_valid), .result_sel(result_sel), .busy(busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_len    = 0;
    m_sel    = 1'b0;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_is_mul = 0; ex_is_div = 0;
    ex_divisor_zero = 0; ex_flush = 0; load_use_stall = 0;
  endtask

  // One clock cycle: check outputs at negedge against the model, then advance it.
  task automatic step(input string tag);
    bit issue, md, e_ms, e_ds, e_ab, e_rv;
    @(negedge clk);
    {md, e_ms, e_ds, e_ab, e_rv} = '0;
    issue = !m_active && ex_valid && (ex_is_mul || ex_is_div) && !ex_flush;
    if (issue) begin
      md   = 1;
      e_ms = !ex_is_div;
      e_ds = ex_is_div && !ex_divisor_zero;
    end else if (m_active && m_pos <= m_len) begin
      if (ex_flush) e_ab = 1; else md = 1;
    end else if (m_active) begin
      if (ex_flush) e_ab = 1; else e_rv = 1;
    end
    chk({tag, ".mul_start"},     mul_start,     e_ms);
    chk({tag, ".div_start"},     div_start,     e_ds);
    chk({tag, ".unit_abort"},    unit_abort,    e_ab);
    chk({tag, ".result_valid"},  result_valid,  e_rv);
    chk({tag, ".stall_front"},   stall_front,   md | load_use_stall);
    chk({tag, ".id_ex_bubble"},  id_ex_bubble,  load_use_stall & ~md);
    chk({tag, ".ex_mem_bubble"}, ex_mem_bubble, md);
    chk({tag, ".result_sel"},    result_sel,    m_sel);
    chk({tag, ".busy"},          busy,          m_active);
    o_stall = stall_front; o_ms = mul_start; o_ds = div_start;
    o_rv = result_valid; o_ab = unit_abort;
    @(posedge clk);
    if (issue) begin
      m_active = 1;
      m_pos    = 1;
      m_len    = ex_is_div ? (ex_divisor_zero ? 0 : DIV_N) : MUL_N;
      m_sel    = ex_is_div;
    end else if (m_active) begin
      if (ex_flush) m_active = 0;
      else begin
        m_pos++;
        if (m_pos > m_len + 1) m_active = 0;
      end
    end
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".mul_start"},     mul_start,     1'b0);
    chk({tag, ".div_start"},     div_start,     1'b0);
    chk({tag, ".unit_abort"},    unit_abort,    1'b0);
    chk({tag, ".result_valid"},  result_valid,  1'b0);
    chk({tag, ".result_sel"},    result_sel,    1'b0);
    chk({tag, ".busy"},          busy,          1'b0);
    chk({tag, ".ex_mem_bubble"}, ex_mem_bubble, 1'b0);
    chk({tag, ".stall_front"},   stall_front,   load_use_stall);
    chk({tag, ".id_ex_bubble"},  id_ex_bubble,  load_use_stall);
  endtask

  initial begin
    int cnt_stall, cnt_rv, cnt_ms, cnt_ds, cnt_ab;

    // Reset with a pending MUL and a load-use stall present
    rst = 1; idle_inputs();
    ex_valid = 1; ex_is_mul = 1; load_use_stall = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 check_reset("rst_lus1");
    load_use_stall = 0;
    #1 check_reset("rst_lus0");
    @(posedge clk); #1;
    rst = 0; idle_inputs();
    step("idle0");

    // MUL: start in cycle 0, stalls cycles 0-2, done cycle 3, idle cycle 4
    ex_valid = 1; ex_is_mul = 1;
    cnt_stall = 0; cnt_ms = 0;
    for (int i = 0; i < 4; i++) begin
      step("mul");
      if (i == 0) chk("mul.c0_start", o_ms, 1'b1);
      cnt_ms += int'(o_ms); cnt_stall += int'(o_stall);
    end
    chk("mul.c3_valid", o_rv, 1'b1);
    chk("mul.c3_sel", result_sel, 1'b0);
    chk_int("mul.stalls", cnt_stall, 3);
    chk_int("mul.starts", cnt_ms, 1);
    idle_inputs();
    step("mul_after");
    chk("mul.c4_busy", busy, 1'b0);

    // DIV by 7: 33 stall cycles, result in cycle 33
    ex_valid = 1; ex_is_div = 1;
    cnt_stall = 0; cnt_ds = 0;
    for (int i = 0; i < 34; i++) begin
      step("div");
      cnt_ds += int'(o_ds); cnt_stall += int'(o_stall);
    end
    chk_int("div.stalls", cnt_stall, 33);
    chk_int("div.starts", cnt_ds, 1);
    chk("div.c33_valid", o_rv, 1'b1);
    chk("div.c33_sel", result_sel, 1'b1);
    idle_inputs();
    step("div_after");

    // Divide by zero: no start, one stall, result in cycle 1
    ex_valid = 1; ex_is_div = 1; ex_divisor_zero = 1;
    step("dz0");
    chk("dz.c0_nostart", o_ds, 1'b0);
    chk("dz.c0_stall", o_stall, 1'b1);
    step("dz1");
    chk("dz.c1_valid", o_rv, 1'b1);
    chk("dz.c1_stall", o_stall, 1'b0);
    idle_inputs();
    step("dz_after");

    // DIV flushed in cycle 10
    ex_valid = 1; ex_is_div = 1;
    cnt_rv = 0;
    for (int i = 0; i < 10; i++) begin
      step("dfl");
      cnt_rv += int'(o_rv);
    end
    ex_flush = 1;
    step("dfl_c10");
    chk("dfl.c10_abort", o_ab, 1'b1);
    chk("dfl.c10_stall", o_stall, 1'b0);
    idle_inputs();
    step("dfl_c11");
    chk("dfl.c11_busy", busy, 1'b0);
    cnt_rv += int'(o_rv);
    chk_int("dfl.no_result", cnt_rv, 0);

    // Load-use during DIV_RUN, then in IDLE
    ex_valid = 1; ex_is_div = 1;
    step("lu_issue");
    load_use_stall = 1;
    for (int i = 0; i < 4; i++) step("lu_run");
    chk("lu.run_bubble", id_ex_bubble, 1'b0);
    load_use_stall = 0;
    for (int i = 0; i < 29; i++) step("lu_rest");
    idle_inputs(); load_use_stall = 1;
    step("lu_idle");
    chk("lu.idle_bubble", o_stall & id_ex_bubble, 1'b1);
    load_use_stall = 0;

    // MUL then DIV back-to-back, async reset in DIV_RUN cycle 5
    ex_valid = 1; ex_is_mul = 1;
    for (int i = 0; i < 4; i++) step("b2b_mul");
    ex_is_mul = 0; ex_is_div = 1;
    step("b2b_div_issue");
    chk("b2b.div_start", o_ds, 1'b1);
    for (int i = 0; i < 5; i++) step("b2b_div_run");
    #2 rst = 1;
    #1 model_reset();
    check_reset("b2b_rst");
    @(posedge clk); #1;
    rst = 0; idle_inputs();
    step("b2b_post");

    // Random traffic
    cnt_ab = 0;
    for (int i = 0; i < 1500; i++) begin
      ex_valid        = 1'($urandom_range(0, 3) != 0);
      ex_is_mul       = 1'($urandom);
      ex_is_div       = 1'($urandom_range(0, 2) == 0);
      ex_divisor_zero = 1'($urandom_range(0, 5) == 0);
      ex_flush        = 1'($urandom_range(0, 15) == 0);
      load_use_stall  = 1'($urandom_range(0, 4) == 0);
      step("rnd");
      cnt_ab += int'(o_ab);
    end
    idle_inputs();
    for (int i = 0; i < 40; i++) step("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_pipeline_sequencer.md
Name: muldiv_pipeline_sequencer

Overview:
- Controller for the shared multi-cycle M-extension units (iterative multiplier and divider) in the EX stage of the 5-stage RISC32IM pipeline.
- Issues start and abort pulses to the units and counts their fixed latency.
- Freezes the front of the pipeline while a unit is busy, and merges the load-use stall from hazard detection into one coherent stall/bubble control set.

Parameters:
- MUL_CYCLES, 2, execution cycles of the iterative multiplier (>=1).
- DIV_CYCLES, 32, execution cycles of the iterative divider (>=1).
- CNT_W, 6, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_is_mul  input  1  EX instruction is MUL/MULH/MULHSU/MULHU.
- ex_is_div  input  1  EX instruction is DIV/DIVU/REM/REMU.
- ex_divisor_zero  input  1  rs2 operand in EX equals 0.
- ex_flush  input  1  taken-branch/jump flush of the EX stage.
- load_use_stall  input  1  load-use stall from hazard detection.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- div_start  output  1  one-cycle start pulse to the divider.
- unit_abort  output  1  one-cycle pulse; discard the in-flight mul/div.
- stall_front  output  1  hold PC, IF/ID and ID/EX registers.
- id_ex_bubble  output  1  load a NOP into ID/EX.
- ex_mem_bubble  output  1  load a NOP into EX/MEM.
- result_valid  output  1  EX result mux must select the unit result this cycle.
- result_sel  output  1  0 = multiplier, 1 = divider or divide-by-zero result.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset: state IDLE, counter 0, result_sel 0. While reset is asserted all outputs are 0 except those driven combinationally by load_use_stall.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE, issue condition: ex_valid & (ex_is_mul | ex_is_div) & ~ex_flush.
  - If ex_is_div is set, divide takes priority; ex_is_mul is ignored.
  - Divide with ex_divisor_zero=1: no div_start. Go to DONE, result_sel<=1. The unit's result path supplies the RISC-V div-by-zero values (-1 / dividend).
  - Divide with ex_divisor_zero=0: div_start=1, counter<=DIV_CYCLES-1, go to DIV_RUN, result_sel<=1.
  - Multiply: mul_start=1, counter<=MUL_CYCLES-1, go to MUL_RUN, result_sel<=0.
  - stall_front=1 and ex_mem_bubble=1 in the issue cycle.
- MUL_RUN / DIV_RUN:
  - stall_front=1, ex_mem_bubble=1.
  - counter decrements each cycle; when counter==0, go to DONE.
  - Each RUN state therefore lasts exactly N cycles.
- DONE:
  - result_valid=1, stall_front=0, ex_mem_bubble=0; the instruction advances to MEM at this edge.
  - Next state is IDLE.
- EX occupancy per instruction:
  - Normal op: 1 issue + N run + 1 done = N+2 cycles, of which N+1 are stalls.
  - Divide by zero: 2 cycles, 1 stall.
- Back-to-back mul/div: the second op is first seen in IDLE the cycle after DONE. There is no overlap and no lost op.
- Flush: ex_flush in MUL_RUN, DIV_RUN or DONE:
  - unit_abort=1 in that cycle; next state IDLE.
  - result_valid forced 0 that cycle; stall_front and ex_mem_bubble deasserted that cycle so the flush completes.
  - In IDLE, ex_flush suppresses issue; unit_abort stays 0.
- Load-use merge:
  - stall_front = md_stall | load_use_stall.
  - id_ex_bubble = load_use_stall & ~md_stall. While a unit is busy the ID/EX register holds rather than bubbles.
  - ex_mem_bubble depends only on md_stall.
- Reset mid-operation: immediately returns to IDLE and clears all registered state. No abort pulse is generated; the units are reset by the same rst.
- Start, abort and result_valid are never asserted in the same cycle.

Test Plan:
- Reset, then MUL with ex_valid=1 and MUL_CYCLES=2 -> mul_start pulse in cycle 0; stall_front=1 and ex_mem_bubble=1 in cycles 0-2; result_valid=1 with result_sel=0 in cycle 3; busy=0 in cycle 4.
- DIV with divisor 7 and DIV_CYCLES=32 -> div_start in cycle 0; stall_front high for exactly 33 cycles; result_valid with result_sel=1 in cycle 33.
- DIV with ex_divisor_zero=1 -> no div_start; stall_front high for cycle 0 only; result_valid=1 with result_sel=1 in cycle 1.
- DIV issued, then ex_flush in cycle 10 -> unit_abort=1 and stall_front=0 in cycle 10; state IDLE in cycle 11; no result_valid ever asserted.
- load_use_stall=1 while DIV_RUN -> stall_front=1, id_ex_bubble=0; with load_use_stall=1 in IDLE and no mul/div -> stall_front=1, id_ex_bubble=1, ex_mem_bubble=0.
- MUL immediately followed by DIV, then rst pulse in DIV_RUN cycle 5 -> both ops issue with a single DONE cycle between them; after the rst pulse all outputs are 0 and busy=0 asynchronously.
